// File: rtl/dl_pipe_reg.sv
// Multi-stage valid/ready pipeline register where empty stages (bubbles) collapse under stall.
// Define DL_PIPE_REG_OCC_EN to add the registered occupancy output 'occ'.
module dl_pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef DL_PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] inc_v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;

  // A stage may advance if it is empty or everything downstream of it can advance.
  always_comb begin : adv_chain
    logic c;
    c   = out_ready;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      c      = c | ~v[i];
      adv[i] = c;
    end
  end

  assign in_ready = adv[0] & ~flush & ~rst;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    inc_v    = '0;
    inc_v[0] = in_xfer;
    for (int i = 1; i < DEPTH; i++) begin
      inc_v[i] = v[i-1];
    end
  end

  // Data only loads alongside a valid word, so bubbles never overwrite held data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= inc_v[0];
        if (inc_v[0]) begin
          d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= inc_v[i];
          if (inc_v[i]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef DL_PIPE_REG_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic out_xfer;
  assign out_xfer = out_valid & out_ready;

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ <= occ + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ <= occ - OCC_W'(1);
    end
  end
`endif

endmodule
